plugboard_pair_table: RTL and testbench

PLUGBOARD_PAIR_TABLE -- requirements
Module: plugboard_pair_table

---
 rtl/enigma_pkg.sv | 9 +
 rtl/plugboard_pair_table_if.sv | 26 ++
 rtl/plugboard_pair_table_onehot_to_index.sv | 22 ++
 rtl/plugboard_pair_table.sv | 84 ++++++++
 tb/tb_plugboard_pair_table.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/enigma_pkg.sv
// Shared letter constants and types for the plugboard blocks.
package enigma_pkg;
    localparam int LETTERS   = 26;
    localparam int MAX_PAIRS = 10;
    localparam int IDX_W     = 5;

    typedef logic [LETTERS-1:0] letter_t;
    typedef logic [IDX_W-1:0]   letter_idx_t;
endpackage

// File: rtl/plugboard_pair_table_if.sv
// Write, clear and lookup signals of the plugboard pair table.
interface plugboard_pair_table_if #(
    parameter int LETTERS = enigma_pkg::LETTERS
);
    logic               wr_valid;
    logic               wr_ready;
    logic [LETTERS-1:0] wr_a;
    logic [LETTERS-1:0] wr_b;
    logic               wr_err;
    logic               clear;
    logic               lk_valid;
    logic [LETTERS-1:0] lk_in;
    logic [LETTERS-1:0] lk_out;
    logic               lk_out_valid;
    logic [3:0]         pair_count;

    modport master (
        output wr_valid, wr_a, wr_b, clear, lk_valid, lk_in,
        input  wr_ready, wr_err, lk_out, lk_out_valid, pair_count
    );

    modport slave (
        input  wr_valid, wr_a, wr_b, clear, lk_valid, lk_in,
        output wr_ready, wr_err, lk_out, lk_out_valid, pair_count
    );
endinterface

// File: rtl/plugboard_pair_table_onehot_to_index.sv
// Converts a one-hot letter into its index and flags whether exactly one bit is set.
module onehot_to_index
    import enigma_pkg::*;
#(
    parameter int LETTERS = enigma_pkg::LETTERS
) (
    input  logic [LETTERS-1:0] vec_i,
    output letter_idx_t        idx_o,
    output logic               is_onehot_o
);
    localparam logic [LETTERS-1:0] ONE = {{(LETTERS-1){1'b0}}, 1'b1};

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < LETTERS; i++) begin
            if (vec_i[i]) idx_o = idx_o | letter_idx_t'(i);
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit vector
    assign is_onehot_o = (vec_i != '0) && ((vec_i & (vec_i - ONE)) == '0);
endmodule

// File: rtl/plugboard_pair_table.sv
// Symmetric plug-pair table: validated pair writes, clear, and 1-cycle letter lookup.
module plugboard_pair_table
    import enigma_pkg::*;
#(
    parameter int MAX_PAIRS = enigma_pkg::MAX_PAIRS,
    parameter int LETTERS   = enigma_pkg::LETTERS
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    plugboard_pair_table_if.slave bus
);
    localparam logic [LETTERS-1:0] ONE = {{(LETTERS-1){1'b0}}, 1'b1};

    logic [LETTERS-1:0] plugged_q, plugged_d;
    letter_idx_t        partner_q [LETTERS];
    letter_idx_t        partner_d [LETTERS];
    logic [3:0]         count_q, count_d;
    logic               wr_err_q, wr_err_d;
    logic               lk_vld_q, lk_vld_d;
    logic [LETTERS-1:0] lk_out_q, lk_out_d;

    letter_idx_t a_idx, b_idx, lk_idx;
    logic        a_oh, b_oh, lk_oh;
    logic        wr_ready, wr_fire, wr_ok;

    onehot_to_index #(.LETTERS(LETTERS)) u_oh_a  (.vec_i(bus.wr_a),  .idx_o(a_idx),  .is_onehot_o(a_oh));
    onehot_to_index #(.LETTERS(LETTERS)) u_oh_b  (.vec_i(bus.wr_b),  .idx_o(b_idx),  .is_onehot_o(b_oh));
    onehot_to_index #(.LETTERS(LETTERS)) u_oh_lk (.vec_i(bus.lk_in), .idx_o(lk_idx), .is_onehot_o(lk_oh));

    assign wr_ready = (int'(count_q) < MAX_PAIRS) && !bus.clear;
    assign wr_fire  = bus.wr_valid && wr_ready;
    assign wr_ok    = a_oh && b_oh && (bus.wr_a != bus.wr_b)
                      && ((plugged_q & (bus.wr_a | bus.wr_b)) == '0);

    always_comb begin
        plugged_d = plugged_q;
        partner_d = partner_q;
        count_d   = count_q;
        wr_err_d  = wr_fire && !wr_ok;
        lk_vld_d  = bus.lk_valid;
        lk_out_d  = '0;

        // Lookup reads the table as it stands before this cycle's write or clear
        if (bus.lk_valid) begin
            if (lk_oh && plugged_q[lk_idx]) lk_out_d = ONE << partner_q[lk_idx];
            else                            lk_out_d = bus.lk_in;
        end

        if (bus.clear) begin
            plugged_d = '0;
            count_d   = '0;
            for (int i = 0; i < LETTERS; i++) partner_d[i] = '0;
        end else if (wr_fire && wr_ok) begin
            plugged_d        = plugged_q | bus.wr_a | bus.wr_b;
            partner_d[a_idx] = b_idx;
            partner_d[b_idx] = a_idx;
            count_d          = count_q + 4'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            plugged_q <= '0;
            count_q   <= '0;
            wr_err_q  <= 1'b0;
            lk_vld_q  <= 1'b0;
            lk_out_q  <= '0;
            for (int i = 0; i < LETTERS; i++) partner_q[i] <= '0;
        end else begin
            plugged_q <= plugged_d;
            partner_q <= partner_d;
            count_q   <= count_d;
            wr_err_q  <= wr_err_d;
            lk_vld_q  <= lk_vld_d;
            lk_out_q  <= lk_out_d;
        end
    end

    assign bus.wr_ready     = wr_ready;
    assign bus.wr_err       = wr_err_q;
    assign bus.lk_out       = lk_out_q;
    assign bus.lk_out_valid = lk_vld_q;
    assign bus.pair_count   = count_q;
endmodule

// File: tb/tb_plugboard_pair_table.sv
// Bench for plugboard_pair_table: letter-map model compared every cycle plus directed literal checks.
module tb_plugboard_pair_table;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    plugboard_pair_table_if bus ();
    plugboard_pair_table dut (.CLOCK_50(clk), .reset(reset), .bus(bus));

    int passed  = 0;
    int total   = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, got, exp);
    endtask

    function automatic logic [25:0] ltr(input int i);
        logic [25:0] one;
        one = 26'd1;
        return one << i;
    endfunction

    // Model: partner letter index per letter, -1 when unplugged
    int          m_partner [26];
    int          m_count;
    logic        exp_err, exp_lkv;
    logic [25:0] exp_lk;

    function automatic int idx_of(input logic [25:0] v);
        for (int i = 0; i < 26; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [25:0] xlate(input logic [25:0] v);
        if ($countones(v) == 1 && m_partner[idx_of(v)] >= 0) return ltr(m_partner[idx_of(v)]);
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 26; i++) m_partner[i] = -1;
            m_count = 0;
            exp_err = 1'b0;
            exp_lkv = 1'b0;
            exp_lk  = '0;
        end else begin
            exp_lkv = bus.lk_valid;
            exp_lk  = bus.lk_valid ? xlate(bus.lk_in) : 26'd0;
            exp_err = 1'b0;
            if (bus.clear) begin
                for (int i = 0; i < 26; i++) m_partner[i] = -1;
                m_count = 0;
            end else if (bus.wr_valid && m_count < 10) begin
                if ($countones(bus.wr_a) == 1 && $countones(bus.wr_b) == 1 && bus.wr_a != bus.wr_b
                    && m_partner[idx_of(bus.wr_a)] < 0 && m_partner[idx_of(bus.wr_b)] < 0) begin
                    m_partner[idx_of(bus.wr_a)] = idx_of(bus.wr_b);
                    m_partner[idx_of(bus.wr_b)] = idx_of(bus.wr_a);
                    m_count++;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc_pair_count", 32'(bus.pair_count), 32'(m_count));
            check("cyc_wr_ready", 32'(bus.wr_ready), 32'((m_count < 10) && !bus.clear));
            check("cyc_wr_err", 32'(bus.wr_err), 32'(exp_err));
            check("cyc_lk_out_valid", 32'(bus.lk_out_valid), 32'(exp_lkv));
            check("cyc_lk_out", 32'(bus.lk_out), 32'(exp_lk));
        end
    end

    task automatic idle();
        bus.wr_valid = 1'b0; bus.wr_a = '0; bus.wr_b = '0;
        bus.clear = 1'b0; bus.lk_valid = 1'b0; bus.lk_in = '0;
    endtask

    task automatic wr(input logic [25:0] a, input logic [25:0] b);
        bus.wr_valid = 1'b1; bus.wr_a = a; bus.wr_b = b;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0; bus.wr_a = '0; bus.wr_b = '0;
    endtask

    task automatic lk(input string name, input logic [25:0] x, input logic [25:0] exp);
        bus.lk_valid = 1'b1; bus.lk_in = x;
        @(posedge clk); #1;
        bus.lk_valid = 1'b0; bus.lk_in = '0;
        check(name, 32'(bus.lk_out), 32'(exp));
        check({name, "_valid"}, 32'(bus.lk_out_valid), 32'd1);
    endtask

    task automatic clr();
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
    endtask

    localparam int A = 0, B = 1, C = 2, D = 3, E = 4, F = 5, G = 6, Q = 16, Z = 25;

    initial begin
        logic [25:0] three;
        three = 26'h3;
        idle();
        #2 reset = 1'b0;
        started = 1'b1;
        #1;
        check("rst_pair_count", 32'(bus.pair_count), 32'd0);
        check("rst_lk_out_valid", 32'(bus.lk_out_valid), 32'd0);
        check("rst_lk_out", 32'(bus.lk_out), 32'd0);
        check("rst_wr_err", 32'(bus.wr_err), 32'd0);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Pair A/E and lookups
        wr(ltr(A), ltr(E));
        check("ae_wr_err", 32'(bus.wr_err), 32'd0);
        check("ae_count", 32'(bus.pair_count), 32'd1);
        lk("lk_A", ltr(A), ltr(E));
        lk("lk_E", ltr(E), ltr(A));
        lk("lk_Z", ltr(Z), ltr(Z));

        // E already plugged
        wr(ltr(E), ltr(Q));
        check("eq_wr_err", 32'(bus.wr_err), 32'd1);
        check("eq_count", 32'(bus.pair_count), 32'd1);
        @(posedge clk); #1;
        check("eq_err_one_pulse", 32'(bus.wr_err), 32'd0);
        lk("lk_Q", ltr(Q), ltr(Q));

        // Fill to capacity
        clr();
        check("clr_count", 32'(bus.pair_count), 32'd0);
        for (int i = 0; i < 10; i++) wr(ltr(2 * i), ltr(2 * i + 1));
        check("full_count", 32'(bus.pair_count), 32'd10);
        check("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        wr(ltr(20), ltr(21));
        check("over_wr_err", 32'(bus.wr_err), 32'd0);
        check("over_count", 32'(bus.pair_count), 32'd10);
        lk("lk_U", ltr(20), ltr(20));
        lk("lk_full_A", ltr(A), ltr(B));
        lk("lk_nonoh", three, three);

        // Malformed writes
        clr();
        wr(ltr(B), ltr(D));
        wr(ltr(C), ltr(C));
        check("cc_wr_err", 32'(bus.wr_err), 32'd1);
        check("cc_count", 32'(bus.pair_count), 32'd1);
        wr(three, ltr(F));
        check("3_wr_err", 32'(bus.wr_err), 32'd1);
        check("3_count", 32'(bus.pair_count), 32'd1);
        lk("lk_C", ltr(C), ltr(C));
        lk("lk_F", ltr(F), ltr(F));
        lk("lk_B", ltr(B), ltr(D));

        // Clear with lookup in the same cycle
        bus.clear = 1'b1; bus.lk_valid = 1'b1; bus.lk_in = ltr(B);
        @(posedge clk); #1;
        idle();
        check("clr_lk_B", 32'(bus.lk_out), 32'(ltr(D)));
        check("clr_lk_count", 32'(bus.pair_count), 32'd0);
        lk("lk_B_after_clr", ltr(B), ltr(B));

        // Reset during a write and a lookup
        wr(ltr(A), ltr(E));
        bus.wr_valid = 1'b1; bus.wr_a = ltr(F); bus.wr_b = ltr(G);
        bus.lk_valid = 1'b1; bus.lk_in = ltr(A);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(bus.pair_count), 32'd0);
        check("mid_rst_lk_out_valid", 32'(bus.lk_out_valid), 32'd0);
        check("mid_rst_wr_err", 32'(bus.wr_err), 32'd0);
        idle();
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        check("rel_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rel_count", 32'(bus.pair_count), 32'd0);
        check("rel_lk_out_valid", 32'(bus.lk_out_valid), 32'd0);
        check("rel_wr_err", 32'(bus.wr_err), 32'd0);
        lk("lk_A_after_rst", ltr(A), ltr(A));

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
